// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory initiator.
// Holds RV32I load/store width codes, FSM states and legality helpers.
package dmem_pkg;

    localparam int TIMEOUT_CYCLES_DEF = 16;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_R,
        RESP
    } state_t;

    function automatic logic f3_legal(
        input logic       st,
        input logic [2:0] f3
    );
        logic ok;
        ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
        if (!st)
            ok = ok || (f3 == F3_BU) || (f3 == F3_HU);
        return ok;
    endfunction

    // Width is carried in funct3[1:0]; the sign bit does not matter here.
    function automatic logic misaligned(
        input logic [2:0] f3,
        input logic [1:0] a
    );
        logic m;
        m = 1'b0;
        if (f3[1:0] == 2'b01)
            m = a[0];
        else if (f3[1:0] == 2'b10)
            m = (a != 2'b00);
        return m;
    endfunction

endpackage

// File: rtl/dmem_initiator_if.sv
// Word-addressed memory bus between the initiator and a memory.
// Request/grant plus read-data-valid handshake.
interface dmem_initiator_if;

    logic        mem_req;
    logic        mem_we;
    logic [29:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
        input  mem_gnt, mem_rvalid, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
        output mem_gnt, mem_rvalid, mem_rdata
    );

endinterface

// File: rtl/load_align.sv
// Selects the addressed byte/half of a read word and extends it.
// Purely combinational.
module load_align
    import dmem_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  off,
    input  logic [2:0]  funct3,
    output logic [31:0] data
);

    logic [7:0]  b;
    logic [15:0] h;

    always_comb begin
        b    = word[{off, 3'b000} +: 8];
        h    = off[1] ? word[31:16] : word[15:0];
        data = word;
        unique case (funct3)
            F3_B:    data = {{24{b[7]}}, b};
            F3_H:    data = {{16{h[15]}}, h};
            F3_BU:   data = {24'd0, b};
            F3_HU:   data = {16'd0, h};
            default: data = word;
        endcase
    end

endmodule

// File: rtl/dmem_initiator.sv
// CPU load/store to word-bus initiator with lane steering,
// load extraction and a grant/read-data timeout.
module dmem_initiator
    import dmem_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic               req_store,
    input  logic [2:0]         req_funct3,
    input  logic [31:0]        req_addr,
    input  logic [31:0]        req_wdata,
    output logic               resp_valid,
    output logic [31:0]        resp_rdata,
    output logic               resp_err,
    dmem_initiator_if.master   mem
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    state_t        state_q, state_d;
    logic          store_q;
    logic [2:0]    f3_q;
    logic [1:0]    off_q;
    logic [29:0]   addr_q;
    logic [31:0]   wdata_q;
    logic [3:0]    wstrb_q;
    logic [31:0]   rdata_q;
    logic          err_q;
    logic [CW-1:0] cnt_q;

    logic          accept;
    logic          bad;
    logic          tmo;
    logic          busy;
    logic [31:0]   st_wdata;
    logic [3:0]    st_strb;
    logic [31:0]   aligned;

    assign accept = req_valid && (state_q == IDLE);
    assign bad    = !f3_legal(req_store, req_funct3)
                 || misaligned(req_funct3, req_addr[1:0]);
    assign busy   = (state_q == ISSUE) || (state_q == WAIT_R);
    // Last permitted wait cycle; an event arriving now still wins.
    assign tmo    = (cnt_q == CW'(TIMEOUT_CYCLES - 1));

    load_align u_align (
        .word   (mem.mem_rdata),
        .off    (off_q),
        .funct3 (f3_q),
        .data   (aligned)
    );

    always_comb begin
        st_wdata = 32'd0;
        st_strb  = 4'd0;
        if (req_store) begin
            unique case (1'b1)
                req_funct3 == F3_B: begin
                    st_strb  = 4'b0001 << req_addr[1:0];
                    st_wdata = {4{req_wdata[7:0]}};
                end
                req_funct3 == F3_H: begin
                    st_strb  = 4'b0011 << req_addr[1:0];
                    st_wdata = {2{req_wdata[15:0]}};
                end
                req_funct3 == F3_W: begin
                    st_strb  = 4'b1111;
                    st_wdata = req_wdata;
                end
                default: begin
                    st_strb  = 4'd0;
                    st_wdata = 32'd0;
                end
            endcase
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:
                if (accept)
                    state_d = bad ? RESP : ISSUE;
            ISSUE:
                if (mem.mem_gnt)
                    state_d = store_q ? RESP : WAIT_R;
                else if (tmo)
                    state_d = RESP;
            WAIT_R:
                if (mem.mem_rvalid || tmo)
                    state_d = RESP;
            RESP:
                state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            store_q <= 1'b0;
            f3_q    <= 3'd0;
            off_q   <= 2'd0;
            addr_q  <= 30'd0;
            wdata_q <= 32'd0;
            wstrb_q <= 4'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            if (accept) begin
                store_q <= req_store;
                f3_q    <= req_funct3;
                off_q   <= req_addr[1:0];
                addr_q  <= req_addr[31:2];
                wdata_q <= bad ? 32'd0 : st_wdata;
                wstrb_q <= bad ? 4'd0 : st_strb;
                rdata_q <= 32'd0;
                err_q   <= bad;
            end else if (state_q == ISSUE) begin
                if (!mem.mem_gnt && tmo)
                    err_q <= 1'b1;
            end else if (state_q == WAIT_R) begin
                if (mem.mem_rvalid)
                    rdata_q <= aligned;
                else if (tmo)
                    err_q <= 1'b1;
            end
            if (state_d != state_q)
                cnt_q <= '0;
            else if (busy)
                cnt_q <= cnt_q + 1'b1;
            else
                cnt_q <= '0;
        end
    end

    assign req_ready     = (state_q == IDLE);
    assign resp_valid    = (state_q == RESP);
    assign resp_rdata    = rdata_q;
    assign resp_err      = err_q;
    assign mem.mem_req   = (state_q == ISSUE);
    assign mem.mem_we    = (state_q == ISSUE) && store_q;
    assign mem.mem_addr  = addr_q;
    assign mem.mem_wdata = wdata_q;
    assign mem.mem_wstrb = wstrb_q;

endmodule

// File: tb/tb_dmem_initiator.sv
// Directed bench for dmem_initiator: loads, stores, errors,
// grant timeout boundary and reset mid-access.
module tb_dmem_initiator;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;

    int total = 0;
    int bad   = 0;

    dmem_initiator_if mif ();

    dmem_initiator #(.TIMEOUT_CYCLES(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_store  (req_store),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem        (mif)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic st, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd);
        req_valid  = 1'b1;
        req_store  = st;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = wd;
        @(negedge clk);
        req_valid  = 1'b0;
    endtask

    initial begin
        rst            = 1'b1;
        req_valid      = 1'b0;
        req_store      = 1'b0;
        req_funct3     = 3'd0;
        req_addr       = 32'd0;
        req_wdata      = 32'd0;
        mif.mem_gnt    = 1'b0;
        mif.mem_rvalid = 1'b0;
        mif.mem_rdata  = 32'd0;
        repeat (2) @(negedge clk);

        chk("rst_ready", req_ready, 1);
        chk("rst_rvalid", resp_valid, 0);
        chk("rst_err", resp_err, 0);
        chk("rst_rdata", resp_rdata, 0);
        chk("rst_mreq", mif.mem_req, 0);
        chk("rst_we", mif.mem_we, 0);
        chk("rst_addr", mif.mem_addr, 0);
        chk("rst_wdata", mif.mem_wdata, 0);
        chk("rst_wstrb", mif.mem_wstrb, 0);
        rst = 1'b0;
        @(negedge clk);

        // LB 0x103: byte 3 of 0x80AA5566 is 0x80
        send(1'b0, 3'b000, 32'h103, 32'h0);
        chk("lb_mreq", mif.mem_req, 1);
        chk("lb_maddr", mif.mem_addr, 32'h40);
        chk("lb_we", mif.mem_we, 0);
        chk("lb_notready", req_ready, 0);
        mif.mem_gnt = 1'b1;
        @(negedge clk);
        mif.mem_gnt    = 1'b0;
        chk("lb_waitr_mreq", mif.mem_req, 0);
        chk("lb_waitr_rv", resp_valid, 0);
        mif.mem_rvalid = 1'b1;
        mif.mem_rdata  = 32'h80AA5566;
        @(negedge clk);
        mif.mem_rvalid = 1'b0;
        chk("lb_rv", resp_valid, 1);
        chk("lb_rdata", resp_rdata, 32'hFFFFFF80);
        chk("lb_err", resp_err, 0);
        @(negedge clk);
        chk("lb_rv_pulse", resp_valid, 0);
        chk("lb_ready_back", req_ready, 1);

        // SH 0x22 with one stalled grant cycle
        send(1'b1, 3'b001, 32'h22, 32'h1234ABCD);
        chk("sh_mreq", mif.mem_req, 1);
        chk("sh_we", mif.mem_we, 1);
        chk("sh_wstrb", mif.mem_wstrb, 4'b1100);
        chk("sh_wdata", mif.mem_wdata, 32'hABCDABCD);
        chk("sh_maddr", mif.mem_addr, 32'h8);
        @(negedge clk);
        chk("sh_hold_req", mif.mem_req, 1);
        chk("sh_hold_strb", mif.mem_wstrb, 4'b1100);
        mif.mem_gnt = 1'b1;
        @(negedge clk);
        mif.mem_gnt = 1'b0;
        chk("sh_rv", resp_valid, 1);
        chk("sh_err", resp_err, 0);
        chk("sh_we_off", mif.mem_we, 0);
        @(negedge clk);

        // SB 0x1: minimum store latency of 2 cycles
        send(1'b1, 3'b000, 32'h1, 32'h0000005A);
        chk("sb_wstrb", mif.mem_wstrb, 4'b0010);
        chk("sb_wdata", mif.mem_wdata, 32'h5A5A5A5A);
        mif.mem_gnt = 1'b1;
        @(negedge clk);
        mif.mem_gnt = 1'b0;
        chk("sb_rv", resp_valid, 1);
        @(negedge clk);

        // LW misaligned and illegal load funct3
        send(1'b0, 3'b010, 32'h6, 32'h0);
        chk("lw_mis_rv", resp_valid, 1);
        chk("lw_mis_err", resp_err, 1);
        chk("lw_mis_rdata", resp_rdata, 0);
        chk("lw_mis_mreq", mif.mem_req, 0);
        @(negedge clk);
        chk("lw_mis_idle", req_ready, 1);
        send(1'b0, 3'b011, 32'h0, 32'h0);
        chk("f3_011_rv", resp_valid, 1);
        chk("f3_011_err", resp_err, 1);
        chk("f3_011_mreq", mif.mem_req, 0);
        @(negedge clk);

        // LHU 0x8 with no grant for 16 cycles
        send(1'b0, 3'b101, 32'h8, 32'h0);
        repeat (15) @(negedge clk);
        chk("to_cyc16_mreq", mif.mem_req, 1);
        @(negedge clk);
        chk("to_rv", resp_valid, 1);
        chk("to_err", resp_err, 1);
        chk("to_rdata", resp_rdata, 0);
        chk("to_mreq", mif.mem_req, 0);
        @(negedge clk);

        // Same, grant arrives in the 16th cycle and wins
        send(1'b0, 3'b101, 32'h8, 32'h0);
        repeat (15) @(negedge clk);
        chk("gnt16_mreq", mif.mem_req, 1);
        mif.mem_gnt = 1'b1;
        @(negedge clk);
        mif.mem_gnt = 1'b0;
        chk("gnt16_waitr", mif.mem_req, 0);
        chk("gnt16_norv", resp_valid, 0);
        mif.mem_rvalid = 1'b1;
        mif.mem_rdata  = 32'h0000F00D;
        @(negedge clk);
        mif.mem_rvalid = 1'b0;
        chk("gnt16_rv", resp_valid, 1);
        chk("gnt16_rdata", resp_rdata, 32'h0000F00D);
        chk("gnt16_err", resp_err, 0);
        @(negedge clk);

        // Reset while waiting for read data
        send(1'b0, 3'b010, 32'h10, 32'h0);
        mif.mem_gnt = 1'b1;
        @(negedge clk);
        mif.mem_gnt = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rstw_ready", req_ready, 1);
        chk("rstw_mreq", mif.mem_req, 0);
        chk("rstw_rv", resp_valid, 0);
        mif.mem_rvalid = 1'b1;
        mif.mem_rdata  = 32'hDEADBEEF;
        @(negedge clk);
        mif.mem_rvalid = 1'b0;
        chk("rstw_late_rv", resp_valid, 0);
        @(negedge clk);
        chk("rstw_late_rv2", resp_valid, 0);
        chk("rstw_rdata", resp_rdata, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
